// File: rtl/cpu_pkg.sv
// Shared decode definitions for the Stars24 RV32I core: micro-ops, ALU functions,
// opcode constants and the decoded bundle passed from decode to execute.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 32;
    localparam int unsigned REG_W   = 5;

    typedef enum logic [5:0] {
        OP_NOP, OP_ILLEGAL,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } cuop_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_MDU
    } alu_op_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Immediate is kept at 32 bits here; the decoder top sign-extends it to XLEN.
    typedef struct packed {
        cuop_t              op;
        alu_op_t            alu_op;
        logic [IMM_W-1:0]   imm;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               reg_write;
        logic               mem_write;
        logic               mem_read;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic               sign;
        logic [1:0]         mem_size;
        logic               illegal;
    } decode_bundle_t;

    function automatic decode_bundle_t bundle_reset();
        decode_bundle_t b;
        b        = '0;
        b.op     = OP_NOP;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I instruction decoder producing a decode_bundle_t.
// Define RV32M_EN to accept the RV32M multiply/divide encodings.
module decode_comb
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decode_bundle_t     bundle
);

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [IMM_W-1:0] imm_i;
    logic [IMM_W-1:0] imm_s;
    logic [IMM_W-1:0] imm_b;
    logic [IMM_W-1:0] imm_u;
    logic [IMM_W-1:0] imm_j;
    logic             legal;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        bundle        = '0;
        bundle.op     = OP_ILLEGAL;
        bundle.alu_op = ALU_ADD;
        bundle.sign   = 1'b1;
        bundle.rs1    = instr[19:15];
        bundle.rs2    = instr[24:20];
        bundle.rd     = instr[11:7];
        legal         = 1'b1;

        case (opc)
            OPC_LUI: begin
                bundle.op        = OP_LUI;
                bundle.alu_op    = ALU_LUI;
                bundle.imm       = imm_u;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.op        = OP_AUIPC;
                bundle.imm       = imm_u;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                bundle.op        = OP_JAL;
                bundle.imm       = imm_j;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.jump      = 1'b1;
            end
            OPC_JALR: begin
                bundle.op        = OP_JALR;
                bundle.imm       = imm_i;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.jump      = 1'b1;
                legal            = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                bundle.imm    = imm_b;
                bundle.branch = 1'b1;
                case (f3)
                    3'b000: begin bundle.op = OP_BEQ;  bundle.alu_op = ALU_SUB;  end
                    3'b001: begin bundle.op = OP_BNE;  bundle.alu_op = ALU_SUB;  end
                    3'b100: begin bundle.op = OP_BLT;  bundle.alu_op = ALU_SLT;  end
                    3'b101: begin bundle.op = OP_BGE;  bundle.alu_op = ALU_SLT;  end
                    3'b110: begin bundle.op = OP_BLTU; bundle.alu_op = ALU_SLTU; bundle.sign = 1'b0; end
                    3'b111: begin bundle.op = OP_BGEU; bundle.alu_op = ALU_SLTU; bundle.sign = 1'b0; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                bundle.imm       = imm_i;
                bundle.reg_write = 1'b1;
                bundle.mem_read  = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.mem_size  = f3[1:0];
                case (f3)
                    3'b000: bundle.op = OP_LB;
                    3'b001: bundle.op = OP_LH;
                    3'b010: bundle.op = OP_LW;
                    3'b100: begin bundle.op = OP_LBU; bundle.sign = 1'b0; end
                    3'b101: begin bundle.op = OP_LHU; bundle.sign = 1'b0; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                bundle.imm       = imm_s;
                bundle.mem_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.mem_size  = f3[1:0];
                case (f3)
                    3'b000: bundle.op = OP_SB;
                    3'b001: bundle.op = OP_SH;
                    3'b010: bundle.op = OP_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                bundle.imm       = imm_i;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                case (f3)
                    3'b000: bundle.op = OP_ADDI;
                    3'b010: begin bundle.op = OP_SLTI;  bundle.alu_op = ALU_SLT; end
                    3'b011: begin bundle.op = OP_SLTIU; bundle.alu_op = ALU_SLTU; bundle.sign = 1'b0; end
                    3'b100: begin bundle.op = OP_XORI;  bundle.alu_op = ALU_XOR; end
                    3'b110: begin bundle.op = OP_ORI;   bundle.alu_op = ALU_OR;  end
                    3'b111: begin bundle.op = OP_ANDI;  bundle.alu_op = ALU_AND; end
                    3'b001: begin
                        bundle.op     = OP_SLLI;
                        bundle.alu_op = ALU_SLL;
                        legal         = (f7 == F7_BASE);
                    end
                    default: begin
                        // f3 = 101: funct7 selects logical vs arithmetic right shift
                        if (f7 == F7_ALT) begin
                            bundle.op     = OP_SRAI;
                            bundle.alu_op = ALU_SRA;
                        end else begin
                            bundle.op     = OP_SRLI;
                            bundle.alu_op = ALU_SRL;
                            legal         = (f7 == F7_BASE);
                        end
                    end
                endcase
            end
            OPC_OP: begin
                bundle.reg_write = 1'b1;
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            3'b000: bundle.op = OP_ADD;
                            3'b001: begin bundle.op = OP_SLL;  bundle.alu_op = ALU_SLL;  end
                            3'b010: begin bundle.op = OP_SLT;  bundle.alu_op = ALU_SLT;  end
                            3'b011: begin bundle.op = OP_SLTU; bundle.alu_op = ALU_SLTU; bundle.sign = 1'b0; end
                            3'b100: begin bundle.op = OP_XOR;  bundle.alu_op = ALU_XOR;  end
                            3'b101: begin bundle.op = OP_SRL;  bundle.alu_op = ALU_SRL;  end
                            3'b110: begin bundle.op = OP_OR;   bundle.alu_op = ALU_OR;   end
                            default: begin bundle.op = OP_AND; bundle.alu_op = ALU_AND;  end
                        endcase
                    end
                    F7_ALT: begin
                        case (f3)
                            3'b000: begin bundle.op = OP_SUB; bundle.alu_op = ALU_SUB; end
                            3'b101: begin bundle.op = OP_SRA; bundle.alu_op = ALU_SRA; end
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_MULDIV: begin
`ifdef RV32M_EN
                        bundle.alu_op = ALU_MDU;
                        case (f3)
                            3'b000: bundle.op = OP_MUL;
                            3'b001: bundle.op = OP_MULH;
                            3'b010: bundle.op = OP_MULHSU;
                            3'b011: bundle.op = OP_MULHU;
                            3'b100: bundle.op = OP_DIV;
                            3'b101: bundle.op = OP_DIVU;
                            3'b110: bundle.op = OP_REM;
                            default: bundle.op = OP_REMU;
                        endcase
`else
                        legal = 1'b0;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_MISC_MEM: begin
                bundle.op  = OP_FENCE;
                bundle.imm = imm_i;
                legal      = (f3 == 3'b000);
            end
            OPC_SYSTEM: begin
                if (instr[31:7] == 25'h0000000) begin
                    bundle.op = OP_ECALL;
                end else if (instr[31:7] == 25'h0002000) begin
                    bundle.op = OP_EBREAK;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // Unrecognised encodings collapse to a side-effect-free illegal bundle
        if (!legal) begin
            bundle         = '0;
            bundle.op      = OP_ILLEGAL;
            bundle.alu_op  = ALU_ADD;
            bundle.sign    = 1'b1;
            bundle.rs1     = instr[19:15];
            bundle.rs2     = instr[24:20];
            bundle.rd      = instr[11:7];
            bundle.illegal = 1'b1;
        end

        if (bundle.rd == '0) begin
            bundle.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_unit.sv
// Registered RV32I decode stage: decode_comb behind a two-entry skid buffer with
// flush and a saturating illegal-instruction counter. RV32M_EN enables RV32M decode.
module decode_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output cuop_t              out_op,
    output alu_op_t            out_alu_op,
    output logic [XLEN-1:0]    out_imm,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [4:0]         out_rd,
    output logic               out_reg_write,
    output logic               out_mem_write,
    output logic               out_mem_read,
    output logic               out_alu_src,
    output logic               out_branch,
    output logic               out_jump,
    output logic               out_sign,
    output logic [1:0]         out_mem_size,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    typedef struct packed {
        decode_bundle_t  dec;
        logic [XLEN-1:0] pc;
    } entry_t;

    decode_bundle_t   dec_c;
    entry_t           in_entry;
    entry_t           main_q;
    entry_t           skid_q;
    logic             main_valid_q;
    logic             skid_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             advance;

    decode_comb u_decode_comb (
        .instr  (in_instr),
        .bundle (dec_c)
    );

    assign in_entry = '{dec: dec_c, pc: in_pc};
    assign accept   = in_valid && in_ready_q && !flush;
    assign advance  = main_valid_q && out_ready;

    // Skid buffer: main drives the outputs, skid catches the one in-flight word
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '{dec: bundle_reset(), pc: '0};
            skid_q       <= '{dec: bundle_reset(), pc: '0};
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (!main_valid_q || advance) begin
            in_ready_q <= 1'b1;
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                main_valid_q <= accept;
                if (accept) begin
                    main_q <= in_entry;
                end
            end
        end else if (accept) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    // Counts accepted illegal words; flush leaves it alone, reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec_c.illegal && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid_q;
    assign out_op        = main_q.dec.op;
    assign out_alu_op    = main_q.dec.alu_op;
    assign out_imm       = XLEN'($signed(main_q.dec.imm));
    assign out_rs1       = main_q.dec.rs1;
    assign out_rs2       = main_q.dec.rs2;
    assign out_rd        = main_q.dec.rd;
    assign out_reg_write = main_q.dec.reg_write;
    assign out_mem_write = main_q.dec.mem_write;
    assign out_mem_read  = main_q.dec.mem_read;
    assign out_alu_src   = main_q.dec.alu_src;
    assign out_branch    = main_q.dec.branch;
    assign out_jump      = main_q.dec.jump;
    assign out_sign      = main_q.dec.sign;
    assign out_mem_size  = main_q.dec.mem_size;
    assign out_pc        = main_q.pc;
    assign out_illegal   = main_q.dec.illegal;
    assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: expected bundles queued on acceptance, compared on transfer.
module tb_decode_unit;
    import cpu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    cuop_t            out_op;
    alu_op_t          out_alu_op;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_reg_write;
    logic             out_mem_write;
    logic             out_mem_read;
    logic             out_alu_src;
    logic             out_branch;
    logic             out_jump;
    logic             out_sign;
    logic [1:0]       out_mem_size;
    logic [XLEN-1:0]  out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    always #5 clk = ~clk;

    decode_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_alu_src(out_alu_src), .out_branch(out_branch), .out_jump(out_jump), .out_sign(out_sign),
        .out_mem_size(out_mem_size), .out_pc(out_pc), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    // flags = {reg_write, mem_write, mem_read, alu_src, branch, jump, sign}
    typedef struct {
        logic [31:0] instr;
        cuop_t       op;
        alu_op_t     alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  flags;
        logic [1:0]  size;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t             tbl[13];
    exp_t             q[$];
    exp_t             cur;
    logic [CNT_W-1:0] cnt_model;
    bit               last_acc;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: evaluate the handshakes that the coming edge will perform, then advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            cnt_model = '0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("occupancy", 64'(out_valid), 64'(q.size() > 0));
            check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_model));
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    check($sformatf("op@%0h", e.pc), 64'(out_op), 64'(e.op));
                    check($sformatf("alu@%0h", e.pc), 64'(out_alu_op), 64'(e.alu));
                    check($sformatf("imm@%0h", e.pc), 64'(out_imm), 64'(e.imm));
                    check($sformatf("rd@%0h", e.pc), 64'(out_rd), 64'(e.rd));
                    check($sformatf("flags@%0h", e.pc),
                          64'({out_reg_write, out_mem_write, out_mem_read, out_alu_src,
                               out_branch, out_jump, out_sign}), 64'(e.flags));
                    check($sformatf("size@%0h", e.pc), 64'(out_mem_size), 64'(e.size));
                    check($sformatf("illegal@%0h", e.pc), 64'(out_illegal), 64'(e.ill));
                    check("pc_order", 64'(out_pc), 64'(e.pc));
                end
                if (in_valid && in_ready) begin
                    e        = cur;
                    e.pc     = in_pc;
                    last_acc = 1'b1;
                    q.push_back(e);
                    if (e.ill && cnt_model != '1) cnt_model = cnt_model + CNT_W'(1);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [31:0] pc);
        cur      = tbl[idx];
        in_valid = 1'b1;
        in_instr = cur.instr;
        in_pc    = pc;
    endtask

    task automatic send(input int idx, input logic [31:0] pc);
        drive(idx, pc);
        last_acc = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_acc) break;
        end
        check("accept", 64'(last_acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 30 && q.size() > 0; n++) tick();
        check("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tbl[0]  = '{32'hFFF00093, OP_ADDI,    ALU_ADD,  32'hFFFFFFFF, 5'd1,  7'b1001001, 2'b00, 1'b0, 32'h0};
        tbl[1]  = '{32'h123452B7, OP_LUI,     ALU_LUI,  32'h12345000, 5'd5,  7'b1001001, 2'b00, 1'b0, 32'h0};
        tbl[2]  = '{32'hFE000EE3, OP_BEQ,     ALU_SUB,  32'hFFFFFFFC, 5'd29, 7'b0000101, 2'b00, 1'b0, 32'h0};
        tbl[3]  = '{32'h00014083, OP_LBU,     ALU_ADD,  32'h00000000, 5'd1,  7'b1011000, 2'b00, 1'b0, 32'h0};
        tbl[4]  = '{32'h0020A423, OP_SW,      ALU_ADD,  32'h00000008, 5'd8,  7'b0101001, 2'b10, 1'b0, 32'h0};
        tbl[5]  = '{32'h010000EF, OP_JAL,     ALU_ADD,  32'h00000010, 5'd1,  7'b1001011, 2'b00, 1'b0, 32'h0};
        tbl[6]  = '{32'h402081B3, OP_SUB,     ALU_SUB,  32'h00000000, 5'd3,  7'b1000001, 2'b00, 1'b0, 32'h0};
        tbl[7]  = '{32'h0020B233, OP_SLTU,    ALU_SLTU, 32'h00000000, 5'd4,  7'b1000000, 2'b00, 1'b0, 32'h0};
        tbl[8]  = '{32'h00000013, OP_ADDI,    ALU_ADD,  32'h00000000, 5'd0,  7'b0001001, 2'b00, 1'b0, 32'h0};
        tbl[9]  = '{32'h00000000, OP_ILLEGAL, ALU_ADD,  32'h00000000, 5'd0,  7'b0000001, 2'b00, 1'b1, 32'h0};
        tbl[10] = '{32'h40335293, OP_SRAI,    ALU_SRA,  32'h00000403, 5'd5,  7'b1001001, 2'b00, 1'b0, 32'h0};
        tbl[11] = '{32'h02109093, OP_ILLEGAL, ALU_ADD,  32'h00000000, 5'd1,  7'b0000001, 2'b00, 1'b1, 32'h0};
`ifdef RV32M_EN
        tbl[12] = '{32'h022081B3, OP_MUL,     ALU_MDU,  32'h00000000, 5'd3,  7'b1000001, 2'b00, 1'b0, 32'h0};
`else
        tbl[12] = '{32'h022081B3, OP_ILLEGAL, ALU_ADD,  32'h00000000, 5'd3,  7'b0000001, 2'b00, 1'b1, 32'h0};
`endif
        cur       = tbl[0];
        cnt_model = '0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_cnt", 64'(illegal_cnt), 64'(0));
        check("rst_op", 64'(out_op), 64'(OP_NOP));
        check("rst_alu", 64'(out_alu_op), 64'(ALU_ADD));
        check("rst_imm", 64'(out_imm), 64'(0));
        check("rst_pc", 64'(out_pc), 64'(0));

        // Single-cycle latency
        send(0, 32'h100);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_op", 64'(out_op), 64'(OP_ADDI));
        drain();

        // Back-to-back stream of assorted formats
        for (int i = 1; i < 12; i++) send(i, 32'h200 + 32'(i) * 4);
        drain();

        // Backpressure: two accepted while blocked, then four out in order with no gap
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            drive(3 + k, 32'h300 + 32'(k) * 4);
            tick();
            if (last_acc) k++;
        end
        check("bp_accepted", 64'(k), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_hold_pc", 64'(out_pc), 64'(32'h300));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            drive(3 + k, 32'h300 + 32'(k) * 4);
            tick();
            if (last_acc) k++;
        end
        check("bp_all_sent", 64'(k), 64'(4));
        drain();

        // Flush with both entries full and a word offered
        out_ready = 1'b0;
        send(0, 32'h400);
        send(1, 32'h404);
        drive(9, 32'h408);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        // Flush while ready: the offered illegal word is dropped and not counted
        send(2, 32'h410);
        drive(9, 32'h414);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        send(7, 32'h420);
        drain();

        // Reset mid-operation clears the counter, then MUL
        out_ready = 1'b0;
        send(0, 32'h500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_cnt", 64'(illegal_cnt), 64'(0));
        check("rst2_out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(12, 32'h504);
        drain();
`ifdef RV32M_EN
        check("mul_cnt", 64'(illegal_cnt), 64'(0));
`else
        check("mul_cnt", 64'(illegal_cnt), 64'(1));
`endif

        // Counter saturation
        for (int i = 0; i < 300; i++) send(9, 32'h1000 + 32'(i) * 4);
        drain();
        check("sat_cnt", 64'(illegal_cnt), 64'(255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
# decode_unit

Registered, handshaked RV32I instruction decoder for the Stars24 RISC-V core. It sits between fetch and the register-file/execute stage. It replaces the combinational control unit with a parametrised successor that adds:
- a full-width sign-extended immediate;
- valid/ready flow control with a two-entry skid buffer;
- pipeline flush;
- illegal-instruction detection with a saturating counter;
- optional RV32M decode.

## Interface
Parameters:
- XLEN, 32, datapath width; width of `pc` and `imm`.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_op  out  cuop_t  decoded operation.
- out_alu_op  out  alu_op_t (4)  ALU function.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J format).
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_branch, out_jump, out_sign  out  1 each  control flags.
- out_mem_size  out  2  00 = byte, 01 = half, 10 = word.
- out_pc  out  XLEN  PC passed through with its instruction.
- out_illegal  out  1  instruction is not a recognised encoding.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- Decode is combinational from `in_instr` into a `decode_bundle_t`. The bundle is then registered.
- Buffer holds two entries: main (drives the outputs) and skid.
  - An instruction is accepted when `in_valid && in_ready`.
  - The main entry advances when `out_valid && out_ready`.
  - If an instruction is accepted while the main entry is valid and not advancing, it goes to skid.
  - When main advances, skid (if valid) moves into main.
- `in_ready` = !skid_valid, registered. Throughput is one instruction per cycle while `out_ready` = 1.
- Order is strictly preserved. No instruction is dropped or duplicated, except on flush.
- Immediates:
  - I-type: instr[31:20]. S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}. J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I/S/B/J immediates are sign-extended to XLEN. U-type is {instr[31:12], 12'b0}, sign-extended to XLEN.
  - R-type imm = 0.
- `out_sign` = 0 for LBU/LHU/BLTU/BGEU/SLTIU/SLTU, otherwise 1.
- `out_reg_write` is forced to 0 when rd = 0.
- Illegal instruction:
  - Any opcode/funct3/funct7 combination outside the supported set sets `out_illegal` = 1 and `out_op` = OP_ILLEGAL.
  - All write/mem flags are 0.
  - `illegal_cnt` increments on acceptance and saturates at 2^CNT_W-1.
- Flush: both entries are invalidated at the next edge. Any `in_valid` in the same cycle is dropped and not counted. `in_ready` = 1 on the following cycle. `illegal_cnt` is unaffected.
- Reset mid-operation: identical to flush, and also clears `illegal_cnt`.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs with `out_valid` = 1 after edge N.
- Outputs are held stable while `out_valid && !out_ready`.
- Reset values:
  - `in_ready` = 1; `out_valid` = 0; `illegal_cnt` = 0.
  - `out_op` = OP_NOP; `out_alu_op` = ALU_ADD.
  - All other outputs = 0.
- Simultaneous accept and advance with skid empty: the new instruction enters main directly, with no bubble.
- Full, with `out_ready` = 1: skid moves to main and `in_ready` rises on the next cycle.

## Configuration
- RV32M_EN defined:
  - MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (opcode 0110011, funct7 0000001) decode to their `cuop_t` values with `out_reg_write` = 1.
  - `out_alu_op` = ALU_MDU.
- RV32M_EN undefined: those encodings are illegal. The M enum values still exist in the package but are never produced.

## Structure
- `cpu_pkg` holds the shared definitions:
  - `cuop_t`: all RV32I ops plus OP_NOP and OP_ILLEGAL, and the M ops.
  - `alu_op_t`.
  - opcode constants (OPC_LUI etc.).
  - `decode_bundle_t`, a packed struct of all `out_*` fields.
- Sub-module `decode_comb`: purely combinational instr → `decode_bundle_t`. `decode_unit` wraps it with the skid buffer and the counter.

## Test plan
- Reset, then ADDI x1,x0,-1 (0xFFF00093): one cycle later `out_op` = ADDI, `out_imm` = 0xFFFFFFFF, `out_rd` = 1, `out_reg_write` = 1, `out_alu_src` = 1.
- LUI x5,0x12345 (0x123452B7) → `out_imm` = 0x12345000. BEQ x0,x0,-4 (0xFE000EE3) → `out_imm` = 0xFFFFFFFC, `out_branch` = 1. LBU (0x00014083) → `out_sign` = 0, `out_mem_size` = 00.
- Stream 4 instructions with `out_ready` = 0 for 3 cycles: exactly 2 are accepted, `in_ready` drops to 0, then release yields all 4 in order with no gaps.
- MUL x3,x1,x2 (0x022081B3):
  - with RV32M_EN → `out_op` = MUL, illegal = 0.
  - without → `out_illegal` = 1, `illegal_cnt` 0 → 1.
- 300 illegal words (0x00000000) with CNT_W = 8 → `illegal_cnt` saturates at 255.
- Flush asserted with both entries full and `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and the dropped instruction never appears.
